// File: rtl/ram_result_capture.sv
// Passively snoops processor RAM writes and queues result words into a small FIFO.
// Optional macro RESULT_16BIT_EN: pairs LO_ADDR/HI_ADDR writes into one {hi,lo} entry; else each LO_ADDR write is one entry.
module ram_result_capture #(
    parameter int                   WIDTH     = 8,
    parameter int                   N_ADDRESS = 8,
    parameter logic [N_ADDRESS-1:0] LO_ADDR   = 8'h02,
    parameter logic [N_ADDRESS-1:0] HI_ADDR   = 8'h03,
    parameter int                   DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_ADDRESS-1:0]       ram_addr,
    input  logic [WIDTH-1:0]           ram_data_wr,
    input  logic                       ram_wr_en,
    output logic [2*WIDTH-1:0]         res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(DEPTH):0]     res_count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LO_ADDR == HI_ADDR) begin : g_bad_params
        $error("ram_result_capture: DEPTH must be a power of 2 >= 2 and LO_ADDR != HI_ADDR");
    end

    logic                 wr_lo;
    logic                 push_vld;
    logic [2*WIDTH-1:0]   push_dat;

    assign wr_lo = ram_wr_en && (ram_addr == LO_ADDR);

`ifdef RESULT_16BIT_EN
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LO_HELD = 2'd1,
        HI_HELD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               wr_hi;

    assign wr_hi = ram_wr_en && (ram_addr == HI_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        push_vld = 1'b0;
        push_dat = '0;
        if (wr_lo) begin
            case (state_q)
                EMPTY: begin
                    lo_d    = ram_data_wr;
                    state_d = LO_HELD;
                end
                LO_HELD: begin
                    lo_d = ram_data_wr;
                end
                HI_HELD: begin
                    push_vld = 1'b1;
                    push_dat = {hi_q, ram_data_wr};
                    state_d  = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end else if (wr_hi) begin
            case (state_q)
                EMPTY: begin
                    hi_d    = ram_data_wr;
                    state_d = HI_HELD;
                end
                HI_HELD: begin
                    hi_d = ram_data_wr;
                end
                LO_HELD: begin
                    push_vld = 1'b1;
                    push_dat = {ram_data_wr, lo_q};
                    state_d  = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
`else
    always_comb begin
        push_vld = wr_lo;
        push_dat = {{WIDTH{1'b0}}, ram_data_wr};
    end
`endif

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] hold_q, hold_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               full;
    logic               pop;
    logic               push_acc;
    logic               drop;

    assign res_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = res_valid && res_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_acc  = push_vld && (!full || pop);
    assign drop      = push_vld && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        overflow_d = overflow_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) begin
                mem_q[wr_ptr_q] <= push_dat;
            end
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // While empty the output keeps showing the most recently popped entry.
    assign res_data  = res_valid ? mem_q[rd_ptr_q] : hold_q;
    assign res_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ram_result_capture.sv
// Directed bench for ram_result_capture (default DEPTH=4); covers whichever RESULT_16BIT_EN build is compiled.
module tb_ram_result_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_data_wr;
    logic        ram_wr_en;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_count;
    logic        overflow;
    logic        ovf_clr;

    int vectors;
    int miscompares;

    ram_result_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ram_addr    (ram_addr),
        .ram_data_wr (ram_data_wr),
        .ram_wr_en   (ram_wr_en),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // One clock with the given inputs; outputs are stable 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [7:0] a, input logic [7:0] d,
                       input logic rdy, input logic clr);
        ram_wr_en   = we;
        ram_addr    = a;
        ram_data_wr = d;
        res_ready   = rdy;
        ovf_clr     = clr;
        @(posedge clk);
        #1;
        ram_wr_en = 1'b0;
        res_ready = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    // Produces one FIFO push; rdy/clr are applied on the completing write edge.
    task automatic push_entry(input logic [15:0] v, input logic rdy, input logic clr);
`ifdef RESULT_16BIT_EN
        cyc(1'b1, 8'h02, v[7:0], 1'b0, 1'b0);
        cyc(1'b1, 8'h03, v[15:8], rdy, clr);
`else
        cyc(1'b1, 8'h02, v[7:0], rdy, clr);
`endif
    endtask

    function automatic logic [15:0] exp_of(input logic [15:0] v);
`ifdef RESULT_16BIT_EN
        return v;
`else
        return {8'h00, v[7:0]};
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        vectors++;
        if (res_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", res_count); end
        vectors++;
        if (res_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", res_data); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

`ifdef RESULT_16BIT_EN
    task automatic test_pairing();
        cyc(1'b1, 8'h02, 8'h34, 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd0) begin miscompares++; $display("FAIL pair_half_count: got %0d expected 0", res_count); end
        cyc(1'b1, 8'h03, 8'h12, 1'b0, 1'b0);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 16'h1234 || res_count !== 3'd1) begin
            miscompares++; $display("FAIL pair_lo_hi: got v=%b d=%h c=%0d expected v=1 d=1234 c=1", res_valid, res_data, res_count);
        end
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h03, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 8'h66, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 8'h77, 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd2 || res_data !== 16'hAA55) begin
            miscompares++; $display("FAIL pair_hi_lo_first: got d=%h c=%0d expected d=aa55 c=2", res_data, res_count);
        end
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (res_data !== 16'h7766) begin miscompares++; $display("FAIL pair_second: got %h expected 7766", res_data); end
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h02, 8'h34, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 8'h03, 8'h12, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 8'h56, 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd1 || res_data !== 16'h1256) begin
            miscompares++; $display("FAIL pair_after_reset: got d=%h c=%0d expected d=1256 c=1", res_data, res_count);
        end
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    endtask
`else
    task automatic test_byte_mode();
        cyc(1'b1, 8'h02, 8'h9C, 1'b0, 1'b0);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 16'h009C || res_count !== 3'd1) begin
            miscompares++; $display("FAIL byte_push: got v=%b d=%h c=%0d expected v=1 d=009c c=1", res_valid, res_data, res_count);
        end
        cyc(1'b1, 8'h03, 8'h11, 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd1 || res_data !== 16'h009C) begin
            miscompares++; $display("FAIL byte_hi_ignored: got d=%h c=%0d expected d=009c c=1", res_data, res_count);
        end
        cyc(1'b1, 8'h05, 8'hAB, 1'b0, 1'b0);
        cyc(1'b0, 8'h02, 8'hCD, 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd1) begin miscompares++; $display("FAIL byte_other_ignored: got %0d expected 1", res_count); end
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (res_valid !== 1'b0 || res_count !== 3'd0 || res_data !== 16'h009C) begin
            miscompares++; $display("FAIL byte_pop_hold: got v=%b d=%h c=%0d expected v=0 d=009c c=0", res_valid, res_data, res_count);
        end
    endtask
`endif

    task automatic test_push_pop_same();
        push_entry(16'h4101, 1'b0, 1'b0);
        push_entry(16'h4202, 1'b1, 1'b0);
        vectors++;
        if (res_count !== 3'd1 || res_data !== exp_of(16'h4202)) begin
            miscompares++; $display("FAIL pushpop_mid: got d=%h c=%0d expected d=%h c=1", res_data, res_count, exp_of(16'h4202));
        end
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (res_count !== 3'd0) begin miscompares++; $display("FAIL pushpop_drain: got %0d expected 0", res_count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) push_entry(16'h1510 + 16'(i), 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd4 || overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_full: got c=%0d ovf=%b expected c=4 ovf=1", res_count, overflow);
        end
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (res_data !== exp_of(16'h1510 + 16'(i))) begin
                miscompares++; $display("FAIL ovf_order_%0d: got %h expected %h", i, res_data, exp_of(16'h1510 + 16'(i)));
            end
            cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        vectors++;
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got %b expected 0", res_valid); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) push_entry(16'h2620 + 16'(i), 1'b0, 1'b0);
        push_entry(16'h2624, 1'b1, 1'b0);
        vectors++;
        if (overflow !== 1'b0 || res_count !== 3'd4 || res_data !== exp_of(16'h2621)) begin
            miscompares++; $display("FAIL full_pushpop: got ovf=%b c=%0d d=%h expected ovf=0 c=4 d=%h", overflow, res_count, res_data, exp_of(16'h2621));
        end
        for (int i = 1; i < 5; i++) begin
            vectors++;
            if (res_data !== exp_of(16'h2620 + 16'(i))) begin
                miscompares++; $display("FAIL full_order_%0d: got %h expected %h", i, res_data, exp_of(16'h2620 + 16'(i)));
            end
            cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        vectors++;
        if (res_count !== 3'd0) begin miscompares++; $display("FAIL full_drained: got %0d expected 0", res_count); end
    endtask

    task automatic test_set_wins_and_reset();
        for (int i = 0; i < 4; i++) push_entry(16'h3730 + 16'(i), 1'b0, 1'b0);
        push_entry(16'h3734, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b1 || res_count !== 3'd4) begin
            miscompares++; $display("FAIL set_wins: got ovf=%b c=%0d expected ovf=1 c=4", overflow, res_count);
        end
        do_reset();
        vectors++;
        if (res_valid !== 1'b0 || res_count !== 3'd0 || res_data !== 16'h0000 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset: got v=%b c=%0d d=%h ovf=%b expected v=0 c=0 d=0000 ovf=0", res_valid, res_count, res_data, overflow);
        end
        push_entry(16'h4842, 1'b0, 1'b0);
        vectors++;
        if (res_count !== 3'd1 || res_data !== exp_of(16'h4842)) begin
            miscompares++; $display("FAIL post_reset_push: got d=%h c=%0d expected d=%h c=1", res_data, res_count, exp_of(16'h4842));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ram_addr    = 8'h00;
        ram_data_wr = 8'h00;
        ram_wr_en   = 1'b0;
        res_ready   = 1'b0;
        ovf_clr     = 1'b0;
        test_reset();
`ifdef RESULT_16BIT_EN
        test_pairing();
`else
        test_byte_mode();
`endif
        test_push_pop_same();
        test_overflow();
        test_full_push_pop();
        test_set_wins_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_result_capture.md
RAM_RESULT_CAPTURE -- requirements
Module: ram_result_capture

Interface
REQ-001 Parameter WIDTH, default 8: RAM data word width in bits.
REQ-002 Parameter N_ADDRESS, default 8: RAM address width in bits.
REQ-003 Parameter LO_ADDR, default 8'h02: RAM address of the result low byte.
REQ-004 Parameter HI_ADDR, default 8'h03: RAM address of the result high byte.
REQ-005 Parameter DEPTH, default 4: result FIFO depth in entries, a power of 2 and at least 2.
REQ-006 Port clk, input, 1: single clock; all logic updates on the rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port ram_addr, input, N_ADDRESS: processor RAM address, snooped only.
REQ-009 Port ram_data_wr, input, WIDTH: processor RAM write data, snooped only.
REQ-010 Port ram_wr_en, input, 1: processor RAM write strobe.
REQ-011 Port res_data, output, 2*WIDTH: FIFO head, {hi,lo}.
REQ-012 Port res_valid, output, 1: FIFO not empty.
REQ-013 Port res_ready, input, 1: consumer accepts res_data.
REQ-014 Port res_count, output, log2(DEPTH)+1: FIFO occupancy.
REQ-015 Port overflow, output, 1: sticky flag, set when a result is dropped.
REQ-016 Port ovf_clr, input, 1: clears overflow.

Function
REQ-017 The block is passive: it never drives RAM signals and never stalls the processor.
REQ-018 A write event is any rising edge with ram_wr_en=1; writes to addresses other than LO_ADDR and HI_ADDR are ignored.
REQ-019 Pairing FSM states: EMPTY, LO_HELD, HI_HELD; reset state is EMPTY.
REQ-020 EMPTY: a write to LO_ADDR latches the byte and moves to LO_HELD; a write to HI_ADDR latches the byte and moves to HI_HELD.
REQ-021 LO_HELD: a write to LO_ADDR overwrites the latched low byte and stays; a write to HI_ADDR completes the pair, pushes {hi,lo} and moves to EMPTY.
REQ-022 HI_HELD: the mirror of LO_HELD, with the roles of LO_ADDR and HI_ADDR swapped.
REQ-023 Push latency: a completing write at edge N gives res_valid=1 and the new entry visible after edge N when the FIFO was empty.
REQ-024 Pop occurs on an edge where res_valid=1 and res_ready=1; res_ready is ignored while empty.
REQ-025 A push while full with no simultaneous pop drops the entry, sets overflow and leaves the FIFO unchanged.
REQ-026 A push while full with a simultaneous pop performs both; no overflow is flagged and res_count is unchanged.
REQ-027 A simultaneous push and pop at any other occupancy leaves res_count unchanged.
REQ-028 FIFO pointers wrap modulo DEPTH; res_count ranges 0..DEPTH.
REQ-029 ovf_clr=1 clears overflow at the next edge; if a drop occurs on that same edge, overflow is set (set wins).
REQ-030 res_data is the head entry while res_valid=1 and holds its last value while empty.

Reset
REQ-031 With rst_n=0 at an edge: FSM to EMPTY, latched bytes to 0, pointers to 0, res_count=0, res_valid=0, res_data=0, overflow=0.
REQ-032 Reset mid-operation discards any half-paired byte and all FIFO contents; the first write after reset is treated as starting a new pair.

Configuration
REQ-033 Macro RESULT_16BIT_EN defined: pairing behaves as in REQ-019..REQ-022.
REQ-034 Macro RESULT_16BIT_EN undefined: no FSM; every write to LO_ADDR pushes {WIDTH'h0, byte} immediately; HI_ADDR writes are ignored; all FIFO rules still apply.

Verification
REQ-035 Write 0x34 to addr 2, then 0x12 to addr 3 -> res_valid=1 one edge later, res_data=0x1234, res_count=1.
REQ-036 Write 0xAA to addr 3, then 0x55 to addr 2, then 0x66 to addr 2, then 0x77 to addr 3 -> two entries, 0xAA55 then 0x7766.
REQ-037 res_ready=0, push 5 pairs with DEPTH=4 -> res_count=4, overflow=1, entries are the first four; ovf_clr pulse -> overflow=0.
REQ-038 FIFO full, completing write on the same edge as res_ready=1 -> overflow stays 0, res_count stays 4, the new entry is at the tail.
REQ-039 Write 0x34 to addr 2, rst_n=0 for one edge, write 0x12 to addr 3, write 0x56 to addr 2 -> single entry 0x1256.
REQ-040 Build without RESULT_16BIT_EN; write 0x9C to addr 2 and 0x11 to addr 3 -> single entry 0x009C.
